lap_playback: RTL and testbench

LAP_PLAYBACK -- requirements
Module: lap_playback

---
 rtl/lap_playback.sv | 136 +++++++++++++
 tb/tb_lap_playback.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_playback.sv
// Lap-memory playback sequencer: fetches stored lap times one by one and
// presents each until a display tick advances to the next entry.
module lap_playback #(
  parameter int RD_LAT = 1,
  parameter int LOOP   = 0,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          tick,
  input  logic [AW:0]   count,
  input  logic [31:0]   mem_douta,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   data,
  output logic          data_valid,
  output logic [AW-1:0] index,
  output logic          busy,
  output logic          done
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t              state, state_nxt;
  logic [1:0]          wait_cnt, wait_cnt_nxt;
  logic                mem_en_nxt;
  logic [AW-1:0]       mem_addr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                data_valid_nxt;
  logic [AW-1:0]       index_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  // End compare is done one bit wider so count = 2^AW never overflows, and a
  // count that has shrunk below the current index also reads as "last".
  function automatic logic is_last(input logic [AW-1:0] idx, input logic [AW:0] cnt);
    return ({1'b0, idx} + {{AW{1'b0}}, 1'b1}) >= cnt;
  endfunction

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    mem_en_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    data_nxt       = data;
    data_valid_nxt = data_valid;
    index_nxt      = index;
    done_nxt       = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !stop && (count != '0)) begin
          state_nxt      = FETCH;
          mem_en_nxt     = 1'b1;
          mem_addr_nxt   = '0;
          index_nxt      = '0;
          data_valid_nxt = 1'b0;
        end
      end
      FETCH: begin
        state_nxt    = WAIT;
        wait_cnt_nxt = '0;
      end
      WAIT: begin
        if (wait_cnt == 2'(RD_LAT - 1)) begin
          state_nxt      = HOLD;
          data_nxt       = mem_douta;
          data_valid_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 2'd1;
        end
      end
      HOLD: begin
        if (tick) begin
          if (!is_last(index, count)) begin
            state_nxt    = FETCH;
            mem_en_nxt   = 1'b1;
            index_nxt    = index + {{(AW-1){1'b0}}, 1'b1};
            mem_addr_nxt = index + {{(AW-1){1'b0}}, 1'b1};
          end else if (LOOP != 0) begin
            state_nxt    = FETCH;
            mem_en_nxt   = 1'b1;
            index_nxt    = '0;
            mem_addr_nxt = '0;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort: any in-flight read is dropped, presented data/index are kept.
    if (stop && (state != IDLE)) begin
      state_nxt      = IDLE;
      mem_en_nxt     = 1'b0;
      mem_addr_nxt   = mem_addr;
      data_nxt       = data;
      data_valid_nxt = 1'b0;
      index_nxt      = index;
      done_nxt       = 1'b0;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      index      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      mem_en     <= mem_en_nxt;
      mem_addr   <= mem_addr_nxt;
      data       <= data_nxt;
      data_valid <= data_valid_nxt;
      index      <= index_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_lap_playback.sv
// Bench for lap_playback: a one-shot RD_LAT=1 instance and a looping RD_LAT=2
// instance, each fed by its own behavioural lap memory.
module tb_lap_playback;

  logic clk, reset;
  logic a_start, a_stop, a_tick;
  logic [4:0] a_count;
  logic [31:0] a_douta, a_data;
  logic a_mem_en, a_data_valid, a_busy, a_done;
  logic [3:0] a_mem_addr, a_index;

  logic b_start, b_stop, b_tick;
  logic [4:0] b_count;
  logic [31:0] b_douta, b_rd1, b_data;
  logic b_mem_en, b_data_valid, b_busy, b_done;
  logic [3:0] b_mem_addr, b_index;

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] a_last_data;

  int passed = 0;
  int total = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;

  lap_playback #(.RD_LAT(1), .LOOP(0), .AW(4)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .tick(a_tick),
    .count(a_count), .mem_douta(a_douta), .mem_en(a_mem_en), .mem_addr(a_mem_addr),
    .data(a_data), .data_valid(a_data_valid), .index(a_index), .busy(a_busy), .done(a_done)
  );

  lap_playback #(.RD_LAT(2), .LOOP(1), .AW(4)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .tick(b_tick),
    .count(b_count), .mem_douta(b_douta), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
    .data(b_data), .data_valid(b_data_valid), .index(b_index), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  // Lap memories: one- and two-cycle registered reads
  always @(posedge clk) begin
    if (a_mem_en) a_douta <= mem_a[a_mem_addr];
    if (b_mem_en) b_rd1 <= mem_b[b_mem_addr];
    b_douta <= b_rd1;
  end

  always @(negedge clk) begin
    if (a_done === 1'b1) a_done_cnt++;
    if (b_done === 1'b1) b_done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One complete non-looping playback of n entries with a gap before each tick
  task automatic play_a(input int n, input int gap);
    int d0;
    d0 = a_done_cnt;
    a_start = 1; step(); a_start = 0;
    chk("a_start_busy", a_busy, 1);
    chk("a_start_mem_en", a_mem_en, 1);
    chk("a_start_addr", a_mem_addr, 0);
    chk("a_start_index", a_index, 0);
    step();
    chk("a_fetch_dv", a_data_valid, 0);
    chk("a_wait_mem_en", a_mem_en, 0);
    step();
    for (int i = 0; i < n; i++) begin
      chk("a_data", a_data, mem_a[i]);
      chk("a_index", a_index, i);
      chk("a_dv", a_data_valid, 1);
      repeat (gap) step();
      chk("a_hold_data", a_data, mem_a[i]);
      a_tick = 1; step(); a_tick = 0;
      if (i < n - 1) begin
        chk("a_adv_index", a_index, i + 1);
        chk("a_adv_addr", a_mem_addr, i + 1);
        chk("a_adv_mem_en", a_mem_en, 1);
        chk("a_adv_old_data", a_data, mem_a[i]);
        chk("a_adv_dv", a_data_valid, 1);
        step(); step();
      end else begin
        chk("a_end_done", a_done, 1);
        chk("a_end_busy", a_busy, 0);
        chk("a_end_dv", a_data_valid, 1);
        chk("a_end_index", a_index, i);
        step();
        chk("a_done_pulse", a_done, 0);
      end
    end
    chk("a_done_cnt", a_done_cnt - d0, 1);
    a_last_data = mem_a[n-1];
  endtask

  initial begin
    int d0, n;
    clk = 0; reset = 1;
    a_start = 0; a_stop = 0; a_tick = 0; a_count = 0;
    b_start = 0; b_stop = 0; b_tick = 0; b_count = 0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    step(); step();

    // Reset overrides start/tick
    a_start = 1; a_tick = 1; a_stop = 1; a_count = 3;
    step();
    chk("rst_busy", a_busy, 0);
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_data", a_data, 0);
    chk("rst_dv", a_data_valid, 0);
    chk("rst_index", a_index, 0);
    chk("rst_done", a_done, 0);
    chk("rst_b_busy", b_busy, 0);
    a_start = 0; a_tick = 0; a_stop = 0; reset = 0;
    step();

    // Directed three-lap playback
    mem_a[0] = 32'h0000_0123; mem_a[1] = 32'h0000_0456; mem_a[2] = 32'h0000_0789;
    a_count = 3;
    play_a(3, 10);

    // Randomized contents, lengths and tick spacing, including full depth
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) mem_a[i] = $urandom;
      n = (r == 0) ? 16 : int'($urandom_range(1, 15));
      a_count = 5'(n);
      play_a(n, int'($urandom_range(0, 4)));
    end

    // Empty memory: start ignored
    a_count = 0; a_start = 1; step(); a_start = 0;
    for (int i = 0; i < 3; i++) begin
      chk("cnt0_busy", a_busy, 0);
      chk("cnt0_mem_en", a_mem_en, 0);
      step();
    end

    // stop beats start in IDLE
    a_count = 3; a_start = 1; a_stop = 1; step(); a_start = 0; a_stop = 0;
    chk("stop_start_busy", a_busy, 0);
    chk("stop_start_mem_en", a_mem_en, 0);

    // stop in WAIT discards the pending read
    mem_a[0] = ~a_last_data;
    d0 = a_done_cnt;
    a_start = 1; step(); a_start = 0;
    step();
    chk("stopw_busy_before", a_busy, 1);
    a_stop = 1; step(); a_stop = 0;
    chk("stopw_busy", a_busy, 0);
    chk("stopw_dv", a_data_valid, 0);
    chk("stopw_data", a_data, a_last_data);
    chk("stopw_index", a_index, 0);
    step();
    chk("stopw_data_later", a_data, a_last_data);
    chk("stopw_dv_later", a_data_valid, 0);
    chk("stopw_no_done", a_done_cnt - d0, 0);

    // stop and tick together in HOLD
    a_start = 1; step(); a_start = 0;
    step(); step();
    chk("stoph_dv_before", a_data_valid, 1);
    a_stop = 1; a_tick = 1; step(); a_stop = 0; a_tick = 0;
    chk("stoph_busy", a_busy, 0);
    chk("stoph_dv", a_data_valid, 0);
    chk("stoph_index", a_index, 0);
    chk("stoph_data", a_data, mem_a[0]);
    chk("stoph_mem_en", a_mem_en, 0);
    chk("stoph_no_done", a_done_cnt - d0, 0);

    // count shrinks below index while holding
    a_count = 5;
    a_start = 1; step(); a_start = 0;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      a_tick = 1; step(); a_tick = 0;
      step(); step();
    end
    chk("shrink_index", a_index, 2);
    a_count = 2; step();
    a_tick = 1; step(); a_tick = 0;
    chk("shrink_done", a_done, 1);
    chk("shrink_busy", a_busy, 0);
    chk("shrink_index_kept", a_index, 2);
    chk("shrink_data", a_data, mem_a[2]);
    step();

    // tick held high: one advance per HOLD visit
    a_count = 4; a_tick = 1;
    d0 = a_done_cnt;
    a_start = 1; step(); a_start = 0;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      chk("tickhi_data", a_data, mem_a[i]);
      chk("tickhi_index", a_index, i);
      step();
      if (i < 3) begin step(); step(); end
    end
    repeat (6) step();
    a_tick = 0;
    chk("tickhi_done_cnt", a_done_cnt - d0, 1);
    chk("tickhi_busy", a_busy, 0);
    chk("tickhi_index_end", a_index, 3);

    // start while busy ignored, then reset mid-playback
    a_count = 4;
    d0 = a_done_cnt;
    a_start = 1; step(); a_start = 0;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      a_tick = 1; step(); a_tick = 0;
      step(); step();
    end
    chk("mid_index", a_index, 2);
    a_start = 1; step(); a_start = 0;
    chk("busy_start_index", a_index, 2);
    chk("busy_start_mem_en", a_mem_en, 0);
    chk("busy_start_busy", a_busy, 1);
    reset = 1; a_tick = 1; a_start = 1; step();
    reset = 0; a_tick = 0; a_start = 0;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_dv", a_data_valid, 0);
    chk("midrst_index", a_index, 0);
    chk("midrst_data", a_data, 0);
    chk("midrst_addr", a_mem_addr, 0);
    chk("midrst_mem_en", a_mem_en, 0);
    step();
    chk("midrst_no_done", a_done_cnt - d0, 0);
    play_a(4, 1);

    // Looping instance: two entries, two-cycle read latency
    b_count = 2;
    b_start = 1; step(); b_start = 0;
    chk("b_start_busy", b_busy, 1);
    step();
    chk("b_dv_e1", b_data_valid, 0);
    step();
    chk("b_dv_e2", b_data_valid, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("b_dv", b_data_valid, 1);
      chk("b_index", b_index, k % 2);
      chk("b_data", b_data, mem_b[k % 2]);
      repeat ($urandom_range(0, 3)) step();
      b_tick = 1; step(); b_tick = 0;
      chk("b_adv_index", b_index, (k + 1) % 2);
      chk("b_adv_busy", b_busy, 1);
      step(); step(); step();
    end
    b_stop = 1; step(); b_stop = 0;
    chk("b_stop_busy", b_busy, 0);
    chk("b_stop_dv", b_data_valid, 0);
    chk("b_never_done", b_done_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
